draw_source_scheduler: RTL and testbench

Per-frame sequencer for the shared frame-buffer write port. On each system-domain frame pulse it grants the port to the draw sources one at a time, in fixed painter's order (index 0 = background first). It drives the frame manager's source select and guards each grant with a watchdog. It sits between the frame-pulse crossing and the frame manager, in the 100 MHz system domain.

---
 rtl/draw_sched_pkg.sv | 14 +
 rtl/draw_sched_watchdog.sv | 36 +++
 rtl/draw_source_scheduler.sv | 142 ++++++++++++++
 tb/tb_draw_source_scheduler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/draw_sched_pkg.sv
// Shared types and constants for the draw-source scheduler and frame manager.
package draw_sched_pkg;

    localparam int unsigned SOURCE_SEL_ADDRW = 2;

    typedef enum logic [2:0] {
        StIdle,
        StWaitBuf,
        StScan,
        StGrant,
        StDone
    } sched_state_e;

endpackage

// File: rtl/draw_sched_watchdog.sv
// Grant watchdog: counts enabled cycles and flags the last allowed cycle of a grant.
module draw_sched_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic clk,
    input  logic resetN,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expire_o = en_i && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/draw_source_scheduler.sv
// Per-frame sequencer granting the shared frame-buffer write port to draw sources
// in painter's order, with a per-grant watchdog and sticky status.
module draw_source_scheduler #(
    parameter int unsigned NUM_SOURCES      = 3,
    parameter int unsigned SOURCE_SEL_ADDRW = draw_sched_pkg::SOURCE_SEL_ADDRW,
    parameter int unsigned TIMEOUT_CYCLES   = 500000
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        frame,
    input  logic                        buf_ready,
    input  logic [NUM_SOURCES-1:0]      src_req,
    input  logic [NUM_SOURCES-1:0]      src_done,
    input  logic                        clr_status,
    output logic [NUM_SOURCES-1:0]      src_grant,
    output logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
    output logic                        busy,
    output logic                        frame_done,
    output logic [7:0]                  overrun_cnt,
    output logic [NUM_SOURCES-1:0]      timeout_flags
);

    import draw_sched_pkg::*;

    localparam logic [SOURCE_SEL_ADDRW-1:0] LastIdx = SOURCE_SEL_ADDRW'(NUM_SOURCES - 1);

    sched_state_e                state_q, state_d;
    logic [SOURCE_SEL_ADDRW-1:0] idx_q, idx_d;
    logic [NUM_SOURCES-1:0]      grant_q, grant_d;
    logic [SOURCE_SEL_ADDRW-1:0] sel_q, sel_d;
    logic                        busy_q, busy_d;
    logic                        frame_done_q, frame_done_d;
    logic [7:0]                  overrun_q, overrun_d;
    logic [NUM_SOURCES-1:0]      flags_q, flags_d;
    logic                        in_grant, wd_expire;

    assign in_grant = (state_q == StGrant);

    // Held clear outside GRANT so every new grant starts from zero.
    draw_sched_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .resetN  (resetN),
        .clr_i   (!in_grant),
        .en_i    (in_grant),
        .expire_o(wd_expire)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        flags_d   = flags_q;
        grant_d   = '0;
        sel_d     = '0;

        if (clr_status) begin
            overrun_d = '0;
            flags_d   = '0;
        end

        unique case (state_q)
            StIdle: begin
                idx_d = '0;
                if (frame) state_d = buf_ready ? StScan : StWaitBuf;
            end
            StWaitBuf: begin
                if (buf_ready) state_d = StScan;
            end
            StScan: begin
                if (src_req[idx_q]) begin
                    state_d = StGrant;
                end else if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StGrant: begin
                if (src_done[idx_q] || wd_expire) begin
                    // A done arriving with expiry is a clean finish.
                    if (!src_done[idx_q]) flags_d[idx_q] = 1'b1;
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StScan;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (frame && (state_q != StIdle) && (overrun_d != 8'hFF)) begin
            overrun_d = overrun_d + 8'd1;
        end

        // Outputs are registered from the next state.
        if (state_d == StGrant) begin
            grant_d[idx_d] = 1'b1;
            sel_d          = idx_d;
        end
        busy_d       = (state_d != StIdle);
        frame_done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            grant_q      <= '0;
            sel_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= '0;
            flags_q      <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            grant_q      <= grant_d;
            sel_q        <= sel_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            flags_q      <= flags_d;
        end
    end

    assign src_grant        = grant_q;
    assign write_source_sel = sel_q;
    assign busy             = busy_q;
    assign frame_done       = frame_done_q;
    assign overrun_cnt      = overrun_q;
    assign timeout_flags    = flags_q;

endmodule

// File: tb/tb_draw_source_scheduler.sv
// Directed bench for draw_source_scheduler; cycle t counts from the edge that sees frame (t=0).
module tb_draw_source_scheduler;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       frame = 1'b0;
    logic       buf_ready = 1'b1;
    logic [2:0] src_req = 3'b000;
    logic [2:0] src_done = 3'b000;
    logic       clr_status = 1'b0;
    logic [2:0] src_grant;
    logic [1:0] write_source_sel;
    logic       busy;
    logic       frame_done;
    logic [7:0] overrun_cnt;
    logic [2:0] timeout_flags;

    int n_cmp = 0;
    int n_err = 0;
    int t = 0;

    always #5 clk = ~clk;

    draw_source_scheduler #(
        .NUM_SOURCES     (3),
        .SOURCE_SEL_ADDRW(2),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .frame           (frame),
        .buf_ready       (buf_ready),
        .src_req         (src_req),
        .src_done        (src_done),
        .clr_status      (clr_status),
        .src_grant       (src_grant),
        .write_source_sel(write_source_sel),
        .busy            (busy),
        .frame_done      (frame_done),
        .overrun_cnt     (overrun_cnt),
        .timeout_flags   (timeout_flags)
    );

    // Advance one clock; afterwards the outputs show cycle t.
    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (src_grant !== 3'b000) begin n_err++; $display("FAIL reset_grant got %b want 000", src_grant); end
        n_cmp++; if (write_source_sel !== 2'd0) begin n_err++; $display("FAIL reset_sel got %0d want 0", write_source_sel); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_fdone got %b want 0", frame_done); end
        n_cmp++; if (overrun_cnt !== 8'd0) begin n_err++; $display("FAIL reset_overrun got %0d want 0", overrun_cnt); end
        n_cmp++; if (timeout_flags !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", timeout_flags); end
        resetN = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_all_sources();
        logic [2:0] eg;
        logic [1:0] es;
        src_req = 3'b111; buf_ready = 1'b1; frame = 1'b1; t = 0;
        while (t < 36) begin
            tick();
            frame = 1'b0;
            eg = 3'b000; es = 2'd0;
            if (t >= 2 && t <= 11) begin eg = 3'b001; es = 2'd0; end
            if (t >= 13 && t <= 22) begin eg = 3'b010; es = 2'd1; end
            if (t >= 24 && t <= 33) begin eg = 3'b100; es = 2'd2; end
            n_cmp++; if (src_grant !== eg) begin n_err++; $display("FAIL all_grant t=%0d got %b want %b", t, src_grant, eg); end
            n_cmp++; if (write_source_sel !== es) begin n_err++; $display("FAIL all_sel t=%0d got %0d want %0d", t, write_source_sel, es); end
            n_cmp++; if (busy !== (t >= 1 && t <= 34)) begin n_err++; $display("FAIL all_busy t=%0d got %b", t, busy); end
            n_cmp++; if (frame_done !== (t == 34)) begin n_err++; $display("FAIL all_fdone t=%0d got %b", t, frame_done); end
            src_done = (t == 11) ? 3'b001 : (t == 22) ? 3'b010 : (t == 33) ? 3'b100 : 3'b000;
        end
        src_done = 3'b000;
    endtask

    task automatic test_skip();
        logic [2:0] eg;
        logic [1:0] es;
        src_req = 3'b101; frame = 1'b1; t = 0;
        while (t < 16) begin
            tick();
            frame = 1'b0;
            eg = 3'b000; es = 2'd0;
            if (t >= 2 && t <= 6) eg = 3'b001;
            if (t >= 9 && t <= 13) begin eg = 3'b100; es = 2'd2; end
            n_cmp++; if (src_grant !== eg) begin n_err++; $display("FAIL skip_grant t=%0d got %b want %b", t, src_grant, eg); end
            n_cmp++; if (write_source_sel !== es) begin n_err++; $display("FAIL skip_sel t=%0d got %0d want %0d", t, write_source_sel, es); end
            n_cmp++; if (frame_done !== (t == 14)) begin n_err++; $display("FAIL skip_fdone t=%0d got %b", t, frame_done); end
            // t=4: done from a non-granted source must be ignored
            src_done = (t == 4) ? 3'b010 : (t == 6) ? 3'b001 : (t == 13) ? 3'b100 : 3'b000;
        end
        src_done = 3'b000;
    endtask

    task automatic test_zero_requests();
        src_req = 3'b000; frame = 1'b1; t = 0;
        while (t < 6) begin
            tick();
            frame = 1'b0;
            n_cmp++; if (src_grant !== 3'b000) begin n_err++; $display("FAIL zero_grant t=%0d got %b want 000", t, src_grant); end
            n_cmp++; if (busy !== (t >= 1 && t <= 4)) begin n_err++; $display("FAIL zero_busy t=%0d got %b", t, busy); end
            n_cmp++; if (frame_done !== (t == 4)) begin n_err++; $display("FAIL zero_fdone t=%0d got %b", t, frame_done); end
        end
    endtask

    task automatic test_buf_wait();
        logic [2:0] eg;
        src_req = 3'b001; buf_ready = 1'b0; frame = 1'b1; t = 0;
        while (t < 60) begin
            tick();
            frame = 1'b0;
            eg = (t >= 52 && t <= 55) ? 3'b001 : 3'b000;
            n_cmp++; if (src_grant !== eg) begin n_err++; $display("FAIL wait_grant t=%0d got %b want %b", t, src_grant, eg); end
            n_cmp++; if (busy !== (t >= 1 && t <= 58)) begin n_err++; $display("FAIL wait_busy t=%0d got %b", t, busy); end
            n_cmp++; if (frame_done !== (t == 58)) begin n_err++; $display("FAIL wait_fdone t=%0d got %b", t, frame_done); end
            if (t == 50) buf_ready = 1'b1;
            src_done = (t == 55) ? 3'b001 : 3'b000;
        end
        src_done = 3'b000;
    endtask

    task automatic test_timeout();
        logic [2:0] eg;
        logic [2:0] ef;
        src_req = 3'b111; frame = 1'b1; t = 0;
        while (t < 28) begin
            tick();
            frame = 1'b0;
            eg = 3'b000;
            if (t >= 2 && t <= 4) eg = 3'b001;
            if (t >= 6 && t <= 21) eg = 3'b010;
            if (t >= 23 && t <= 25) eg = 3'b100;
            ef = (t >= 22) ? 3'b010 : 3'b000;
            n_cmp++; if (src_grant !== eg) begin n_err++; $display("FAIL tmo_grant t=%0d got %b want %b", t, src_grant, eg); end
            n_cmp++; if (timeout_flags !== ef) begin n_err++; $display("FAIL tmo_flags t=%0d got %b want %b", t, timeout_flags, ef); end
            n_cmp++; if (frame_done !== (t == 26)) begin n_err++; $display("FAIL tmo_fdone t=%0d got %b", t, frame_done); end
            src_done = (t == 4) ? 3'b001 : (t == 25) ? 3'b100 : 3'b000;
        end
        src_done = 3'b000;
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        n_cmp++; if (timeout_flags !== 3'b000) begin n_err++; $display("FAIL tmo_clear got %b want 000", timeout_flags); end
    endtask

    task automatic test_overrun();
        logic [2:0] eg;
        logic [7:0] eo;
        src_req = 3'b001; frame = 1'b1; t = 0;
        while (t < 15) begin
            tick();
            frame = 1'b0;
            eg = (t >= 2 && t <= 9) ? 3'b001 : 3'b000;
            eo = (t >= 8) ? 8'd3 : (t >= 6) ? 8'd2 : (t >= 4) ? 8'd1 : 8'd0;
            if (t == 15) eo = 8'd0;
            n_cmp++; if (src_grant !== eg) begin n_err++; $display("FAIL ovr_grant t=%0d got %b want %b", t, src_grant, eg); end
            n_cmp++; if (overrun_cnt !== eo) begin n_err++; $display("FAIL ovr_cnt t=%0d got %0d want %0d", t, overrun_cnt, eo); end
            n_cmp++; if (frame_done !== (t == 12)) begin n_err++; $display("FAIL ovr_fdone t=%0d got %b", t, frame_done); end
            frame = (t == 3 || t == 5 || t == 7);
            src_done = (t == 9) ? 3'b001 : 3'b000;
            clr_status = (t == 14);
        end
        clr_status = 1'b0;
        src_done = 3'b000;
    endtask

    task automatic test_reset_mid_grant();
        src_req = 3'b111; frame = 1'b1; t = 0;
        while (t < 5) begin
            tick();
            frame = (t == 3);
        end
        frame = 1'b0;
        n_cmp++; if (src_grant !== 3'b001) begin n_err++; $display("FAIL rst_pre_grant got %b want 001", src_grant); end
        n_cmp++; if (overrun_cnt !== 8'd1) begin n_err++; $display("FAIL rst_pre_ovr got %0d want 1", overrun_cnt); end
        resetN = 1'b0;
        #2;
        n_cmp++; if (src_grant !== 3'b000) begin n_err++; $display("FAIL rst_grant got %b want 000", src_grant); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (overrun_cnt !== 8'd0) begin n_err++; $display("FAIL rst_ovr got %0d want 0", overrun_cnt); end
        n_cmp++; if (write_source_sel !== 2'd0) begin n_err++; $display("FAIL rst_sel got %0d want 0", write_source_sel); end
        tick();
        resetN = 1'b1;
        tick();
        src_req = 3'b110; frame = 1'b1; t = 0;
        while (t < 4) begin
            tick();
            frame = 1'b0;
        end
        // Source 0 not requesting: SCAN at 1 (idx0) and 2 (idx1), grant 1 from cycle 3.
        n_cmp++; if (src_grant !== 3'b010) begin n_err++; $display("FAIL rst_restart_grant got %b want 010", src_grant); end
        n_cmp++; if (write_source_sel !== 2'd1) begin n_err++; $display("FAIL rst_restart_sel got %0d want 1", write_source_sel); end
    endtask

    initial begin
        test_reset();
        test_all_sources();
        test_skip();
        test_zero_requests();
        test_buf_wait();
        test_timeout();
        test_overrun();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
